// File: rtl/jtcop_pkg.sv
// Shared constants and DMA state encoding for the object RAM / sprite buffer block.
package jtcop_pkg;
  localparam int OBJ_AW = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_FLUSH = 2'd2
  } dma_st_t;
endpackage

// File: rtl/jtcop_obj_dpram.sv
// Single-clock dual-port RAM: port A read/write with byte enables, port B read-only.
module jtcop_obj_dpram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_din,
  input  logic [DW/8-1:0]   a_we,
  output logic [DW-1:0]     a_dout,
  input  logic [AW-1:0]     b_addr,
  output logic [DW-1:0]     b_dout
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DW/8; i++)
      if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_dout <= mem[a_addr];
      b_dout <= mem[b_addr];
    end
  end
endmodule

// File: rtl/jtcop_obj_dma.sv
// Object RAM plus shadow sprite buffer; a rising obj_copy snapshots the RAM into the shadow.
module jtcop_obj_dma
  import jtcop_pkg::*;
#(
  parameter int AW = OBJ_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_dout,
  input  logic [1:0]    cpu_dsn,
  input  logic          cpu_rnw,
  input  logic          objram_cs,
  input  logic          obj_copy,
  output logic [15:0]   obj_dout,
  input  logic [AW-1:0] scan_addr,
  output logic [15:0]   scan_data,
  output logic          busy
);
  dma_st_t       st, st_nxt;
  logic          copy_l, req, pend, pend_nxt;
  logic          rd_vld, wr_en;
  logic [AW-1:0] rd_cnt, rd_cnt_nxt, wr_cnt;
  logic [15:0]   rd_data, shd_rd_unused;
  logic [1:0]    cpu_we, shd_we;

  assign req    = obj_copy & ~copy_l;
  assign busy   = (st == ST_COPY) | (st == ST_FLUSH);
  assign cpu_we = {2{objram_cs & ~cpu_rnw}} & ~cpu_dsn;
  // The write issued in the reset cycle is dropped so an aborted copy stops cleanly.
  assign shd_we = {2{wr_en & ~rst}};

  always_comb begin
    st_nxt     = st;
    rd_cnt_nxt = rd_cnt;
    pend_nxt   = pend;
    rd_vld     = 1'b0;
    case (st)
      ST_IDLE:
        if (req) begin
          st_nxt     = ST_COPY;
          rd_cnt_nxt = '0;
        end
      ST_COPY: begin
        rd_vld = 1'b1;
        if (req) pend_nxt = 1'b1;
        if (&rd_cnt) st_nxt = ST_FLUSH;
        else         rd_cnt_nxt = rd_cnt + AW'(1);
      end
      ST_FLUSH:
        if (pend | req) begin
          st_nxt     = ST_COPY;
          rd_cnt_nxt = '0;
          pend_nxt   = 1'b0;
        end else begin
          st_nxt     = ST_IDLE;
        end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      pend   <= 1'b0;
      copy_l <= 1'b0;
      rd_cnt <= '0;
      wr_en  <= 1'b0;
    end else begin
      st     <= st_nxt;
      pend   <= pend_nxt;
      copy_l <= obj_copy;
      rd_cnt <= rd_cnt_nxt;
      wr_en  <= rd_vld;
    end
    wr_cnt <= rd_cnt;
  end

  jtcop_obj_dpram #(.AW(AW), .DW(16)) u_objram (
    .clk    (clk),
    .rst    (rst),
    .a_addr (cpu_addr),
    .a_din  (cpu_dout),
    .a_we   (cpu_we),
    .a_dout (obj_dout),
    .b_addr (rd_cnt),
    .b_dout (rd_data)
  );

  jtcop_obj_dpram #(.AW(AW), .DW(16)) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .a_addr (wr_cnt),
    .a_din  (rd_data),
    .a_we   (shd_we),
    .a_dout (shd_rd_unused),
    .b_addr (scan_addr),
    .b_dout (scan_data)
  );
endmodule
